// File: rtl/bit_index_emitter_pkg.sv
// Shared constants for the bit index emitter.
//   - FSM state encodings (IDLE / SCAN / DONE)
//   - default word, index and count widths
package bit_index_emitter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_IDX_W = 5;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_index_emitter_pos.sv
// bit_pos_finder: combinational priority encoder over a word.
//   vec_i        : word to search
//   idx_o        : position of the lowest set bit (highest when
//                  BIT_INDEX_EMITTER_MSB_FIRST_EN is defined); 0 for an all-zero word
//   single_bit_o : word has exactly one bit set
module bit_pos_finder
  import bit_index_emitter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             single_bit_o
);

  // Later loop iterations overwrite earlier ones, so the scan direction
  // decides which set bit wins.
  always_comb begin
    idx_o = '0;
`ifdef BIT_INDEX_EMITTER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
`endif
  end

  // Clearing the lowest set bit leaves zero only when one bit was set.
  assign single_bit_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/bit_index_emitter.sv
// bit_index_emitter: expands a word into the positions of its set bits,
// one index per valid/ready handshake, then pulses done.
// Optional macro BIT_INDEX_EMITTER_MSB_FIRST_EN emits highest position first.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start, din   : launch a job with din (accepted only when idle)
//   busy         : job in progress (SCAN or DONE)
//   out_valid/out_ready/out_idx/out_last : index stream handshake
//   done         : one-cycle pulse ending each job
//   count        : indices transferred in the current or last job
module bit_index_emitter
  import bit_index_emitter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] pos;
  logic             single;
  logic             xfer;

  bit_pos_finder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pos (
    .vec_i        (shadow_q),
    .idx_o        (pos),
    .single_bit_o (single)
  );

  assign xfer = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = din;
          count_d  = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (shadow_q == '0) begin
          state_d = S_DONE;
        end else if (xfer) begin
          // Clearing the bit just emitted works for either scan direction.
          shadow_d = shadow_q & ~(WIDTH'(1) << pos);
          count_d  = count_q + CNT_W'(1);
          if (single) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_SCAN) && (shadow_q != '0);
    out_idx   = out_valid ? pos : '0;
    out_last  = out_valid && single;
    done      = (state_q == S_DONE);
    count     = count_q;
  end

endmodule

// File: tb/tb_bit_index_emitter.sv
module tb_bit_index_emitter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] din;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        done;
  logic [5:0]  count;

  int total;
  int bad;

  bit_index_emitter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    din   = $urandom;
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %0h want 0", out_last); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0h want 0", done); end
    total++; if (out_idx !== 5'd0) begin bad++; $display("FAIL reset_idx: got %0h want 0", out_idx); end
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", count); end
    reset = 1'b0;
    start = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %0h want 0", busy); end
  endtask

  // mode 0: out_ready tied high; 1: random ready; 2: ready low for cycles 1..3
  task automatic run_job(input logic [31:0] w, input int mode, input string name);
    int   q[$];
    int   k;
    int   nx;
    int   c;
    int   guard;
    logic rdy;
    logic exp_last;
    q = {};
    for (int i = 0; i < 32; i++) begin
      if (w[i]) begin
`ifdef BIT_INDEX_EMITTER_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
    k  = q.size();
    nx = 0;
    din = w;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    if (k == 0) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy0: got %0h want 1", name, busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_valid0: got %0h want 0", name, out_valid); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_early_done: got %0h want 0", name, done); end
      start = 1'b1;
      din = $urandom;
      tick();
      start = 1'b0;
      c = 2;
    end
    guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      exp_last = (q.size() == 1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid c=%0d: got %0h want 1", name, c, out_valid); end
      total++; if (out_idx !== 5'(q[0])) begin bad++; $display("FAIL %s_idx c=%0d: got %0d want %0d", name, c, out_idx, q[0]); end
      total++; if (out_last !== exp_last) begin bad++; $display("FAIL %s_last c=%0d: got %0h want %0h", name, c, out_last, exp_last); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_mid c=%0d: got %0h want 0", name, c, done); end
      total++; if (count !== 6'(nx)) begin bad++; $display("FAIL %s_count_mid c=%0d: got %0d want %0d", name, c, count, nx); end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 2) rdy = (c > 3);
      else                rdy = 1'($urandom % 2);
      out_ready = rdy;
      start = (($urandom % 3) == 0);
      din = $urandom;
      tick();
      c++;
      guard++;
      if (rdy) begin
        void'(q.pop_front());
        nx++;
      end
    end
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d cycles want <2000", name, guard);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done c=%0d: got %0h want 1", name, c, done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_at_done: got %0h want 0", name, out_valid); end
    total++; if (count !== 6'(k)) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, count, k); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_at_done: got %0h want 1", name, busy); end
    start = 1'b0;
    out_ready = 1'($urandom % 2);
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got %0h want 0", name, done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy: got %0h want 0", name, busy); end
    total++; if (count !== 6'(k)) begin bad++; $display("FAIL %s_count_hold: got %0d want %0d", name, count, k); end
  endtask

  task automatic test_zero();
    run_job(32'h0000_0000, 0, "zero");
  endtask

  task automatic test_sparse();
    run_job(32'h8000_0011, 0, "sparse");
  endtask

  task automatic test_full();
    run_job(32'hFFFF_FFFF, 0, "full");
  endtask

  task automatic test_stall();
    run_job(32'h0000_0006, 2, "stall");
  endtask

  task automatic test_reset_mid();
    din = 32'h0000_00F0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // two transfers have happened; abandon the job
    reset = 1'b1;
    start = 1'b1;
    din = $urandom;
    tick();
    reset = 1'b0;
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0h want 0", busy); end
    total++; if (count !== 6'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0h want 0", out_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %0h want 0", done); end
    total++; if (out_idx !== 5'd0) begin bad++; $display("FAIL midrst_idx: got %0d want 0", out_idx); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_no_done: got %0h want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: got %0h want 0", busy); end
    run_job(32'h0000_0300, 1, "after_rst");
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int j = 0; j < 20; j++) begin
      case (j % 3)
        0: w = $urandom & $urandom & $urandom;
        1: w = $urandom;
        default: w = $urandom | $urandom;
      endcase
      run_job(w, 1, "random");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    din = '0;
    out_ready = 1'b0;
    test_reset();
    test_zero();
    test_sparse();
    test_full();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_index_emitter.md
Name: bit_index_emitter

Overview:
- Multi-cycle unit that takes a 32-bit word and emits the bit index of each set bit, one per handshake, lowest index first.
- Ends each job with a one-cycle done pulse and a final set-bit count.
- Performs the reverse of a population counter: it expands a word into the positions of its set bits.
- Sits beside the ALU as a multi-cycle helper for bit-manipulation instructions and for sequential mask walking.

Parameters:
- WIDTH, 32, input word width.
- IDX_W, 5, index width; must equal log2(WIDTH).
- CNT_W, 6, count width; must equal IDX_W+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launches a job with din; honoured only in IDLE.
- din  input  WIDTH  word to decompose; sampled when start is accepted.
- busy  output  1  high in SCAN and DONE.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  current index is the final one for this job.
- done  output  1  one-cycle pulse ending each job.
- count  output  CNT_W  number of indices transferred in the current or last job.

Behaviour:
- Reset (synchronous, active-high):
  - state returns to IDLE.
  - Shadow register and count clear to 0.
  - busy, out_valid, out_last and done are 0; out_idx is 0.
  - Applies mid-job as well: the job is abandoned and no done pulse is issued.
- IDLE:
  - busy=0.
  - When start=1: shadow<=din, count<=0, go to SCAN next cycle.
  - Latency: first out_valid appears 1 cycle after start is sampled.
- SCAN:
  - If shadow==0: out_valid=0, go to DONE. A zero word gives no indices, done one cycle later, count=0.
  - Otherwise out_valid=1 and out_idx = position of the lowest set bit of shadow.
  - out_last = 1 when shadow has exactly one bit set, i.e. (shadow & (shadow-1))==0.
  - Handshake:
    - A transfer happens when out_valid && out_ready.
    - On a transfer: shadow <= shadow & (shadow-1), count <= count+1.
    - If out_last was high, go to DONE.
  - When out_ready=0: out_idx, out_last and shadow hold stable, and out_valid stays high. Indices are never dropped or reordered.
  - Throughput: one index per cycle while out_ready stays high.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, then return to IDLE.
  - count holds its final value until the next accepted start or reset.
- start while busy is ignored and has no side effects. start in the same cycle as reset loses to reset.
- Width rules:
  - count ranges 0..32. din=0xFFFFFFFF gives 32 transfers and count=6'd32.
  - out_idx for WIDTH=32 covers 0..31.
- Cycle total for k set bits with out_ready tied high: start accepted at cycle 0, indices at cycles 1..k, done at cycle k+1. For k=0, done is at cycle 2.

Optional Feature:
- Macro: BIT_INDEX_EMITTER_MSB_FIRST_EN.
- When defined:
  - Indices are emitted highest position first.
  - On each transfer the highest set bit of shadow is cleared.
  - out_last keeps the same single-bit test.
- When undefined: lowest position first, as described in Behaviour.
- Handshake, latency, count and done timing are identical in both builds.

Decomposition:
- Shared constants header holds:
  - state encodings: S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2;
  - WIDTH/IDX_W/CNT_W defaults.
- One sub-module, bit_pos_finder: a combinational priority encoder.
  - Inputs: WIDTH-bit vector.
  - Outputs: IDX_W index and a single_bit flag.
  - Selects the lowest or highest set bit depending on BIT_INDEX_EMITTER_MSB_FIRST_EN.
- The top level holds the FSM, the shadow register, count and the handshake.

Test Plan:
- din=32'h0000_0000, start one cycle -> no out_valid; done pulses 2 cycles after start; count=0.
- din=32'h8000_0011, out_ready=1 -> out_idx sequence 0,4,31 on consecutive cycles; out_last only with 31; done next cycle; count=3.
- din=32'hFFFF_FFFF, out_ready=1 -> indices 0..31 on consecutive cycles; count=32; done at cycle 33.
- din=32'h0000_0006, out_ready=0 for 3 cycles and then 1 -> out_idx=1 held stable with out_valid=1 while stalled; then indices 1,2; count=2.
- din=32'h0000_00F0 started, reset asserted after the second transfer -> next cycle: IDLE, count=0, no done pulse. A start with a new din is accepted normally afterwards, and a start asserted mid-job is ignored.
- MSB_FIRST build, din=32'h8000_0011 -> indices 31,4,0; out_last with 0; count=3.
